// File: rtl/sp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_mem_arbiter
// Description : Two-requester arbiter for a single-port 1-cycle-latency RAM with
//               sticky ownership and a burst cap; read data tagged per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_mem_arbiter #(
    parameter int WIDTH     = 128,
    parameter int ADDR      = 10,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [ADDR-1:0]  r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [ADDR-1:0]  r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic [WIDTH-1:0] r1_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_streak;
    logic             r_rv0;
    logic             r_rv1;

    logic             w_cap;
    logic             w_g0;
    logic             w_g1;

    assign w_cap = (r_streak == C_MAX);

    // Grants are masked while rst is low so nothing reaches the RAM during reset.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (rst) begin
            case (r_state)
                S_OWN0: begin
                    if (r0_req && (!r1_req || !w_cap)) w_g0 = 1'b1;
                    else if (r1_req)                   w_g1 = 1'b1;
                end
                S_OWN1: begin
                    if (r1_req && (!r0_req || !w_cap)) w_g1 = 1'b1;
                    else if (r0_req)                   w_g0 = 1'b1;
                end
                default: begin
                    if (r0_req && r1_req) begin
                        w_g0 = r_last;
                        w_g1 = !r_last;
                    end else begin
                        w_g0 = r0_req;
                        w_g1 = r1_req;
                    end
                end
            endcase
        end
    end

    assign r0_gnt    = w_g0;
    assign r1_gnt    = w_g1;
    assign mem_en    = w_g0 | w_g1;
    assign mem_we    = (w_g0 & r0_we) | (w_g1 & r1_we);
    assign mem_addr  = w_g0 ? r0_addr  : (w_g1 ? r1_addr  : '0);
    assign mem_din   = w_g0 ? r0_wdata : (w_g1 ? r1_wdata : '0);

    assign r0_rvalid = r_rv0;
    assign r1_rvalid = r_rv1;
    assign r0_rdata  = mem_dout;
    assign r1_rdata  = mem_dout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_streak <= '0;
            r_rv0    <= 1'b0;
            r_rv1    <= 1'b0;
        end else begin
            r_rv0 <= w_g0 & ~r0_we;
            r_rv1 <= w_g1 & ~r1_we;
            if (w_g0) begin
                r_state  <= S_OWN0;
                r_last   <= 1'b0;
                r_streak <= (r_state == S_OWN0) ? (w_cap ? r_streak : r_streak + C_ONE) : C_ONE;
            end else if (w_g1) begin
                r_state  <= S_OWN1;
                r_last   <= 1'b1;
                r_streak <= (r_state == S_OWN1) ? (w_cap ? r_streak : r_streak + C_ONE) : C_ONE;
            end else begin
                r_state  <= S_IDLE;
                r_streak <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_mem_arbiter.sv
`default_nettype none
// Bench for sp_mem_arbiter: two instances (burst cap 16 and cap 1) share stimulus,
// each with its own RAM and a run-length reference model.
module tb_sp_mem_arbiter;
    localparam int WIDTH = 128;
    localparam int ADDR  = 10;
    localparam int DEPTH = 1 << ADDR;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [ADDR-1:0]  r0_addr = '0, r1_addr = '0;
    logic [WIDTH-1:0] r0_wdata = '0, r1_wdata = '0;

    logic [1:0]       g0, g1, rv0, rv1, men, mwe;
    logic [ADDR-1:0]  maddr [2];
    logic [WIDTH-1:0] mdin [2], mdout [2], rd0 [2], rd1 [2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_inst
        logic [WIDTH-1:0] ram [DEPTH];

        sp_mem_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .MAX_BURST(k == 0 ? 16 : 1), .CNT_W(5)) u_dut (
            .clk(clk), .rst(rst),
            .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
            .r0_gnt(g0[k]), .r0_rvalid(rv0[k]), .r0_rdata(rd0[k]),
            .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
            .r1_gnt(g1[k]), .r1_rvalid(rv1[k]), .r1_rdata(rd1[k]),
            .mem_en(men[k]), .mem_we(mwe[k]), .mem_addr(maddr[k]), .mem_din(mdin[k]),
            .mem_dout(mdout[k])
        );

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
                mdout[k] <= '0;
            end else if (men[k]) begin
                if (mwe[k]) ram[maddr[k]] <= mdin[k];
                else        mdout[k] <= ram[maddr[k]];
            end
        end
    end

    // Reference model: owner (-1 = none), last winner, length of current run.
    int               m_own [2];
    int               m_last [2];
    int               m_run [2];
    bit               m_pv0 [2];
    bit               m_pv1 [2];
    logic [WIDTH-1:0] m_pd [2];
    logic [WIDTH-1:0] em [2][DEPTH];
    int               cur_g [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int eg(int k, bit q0, bit q1);
        int cap;
        cap = (k == 0) ? 16 : 1;
        if (!q0 && !q1) return -1;
        if (q0 != q1)   return q0 ? 0 : 1;
        if (m_own[k] < 0) return 1 - m_last[k];
        if (m_run[k] < cap) return m_own[k];
        return 1 - m_own[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_last[k] = 1; m_run[k] = 0;
            m_pv0[k] = 0;  m_pv1[k] = 0;  m_pd[k] = '0;
            for (int i = 0; i < DEPTH; i++) em[k][i] = '0;
        end
    endtask

    task automatic drive_check(input bit q0, input bit w0, input logic [ADDR-1:0] a0, input logic [WIDTH-1:0] d0,
                               input bit q1, input bit w1, input logic [ADDR-1:0] a1, input logic [WIDTH-1:0] d1);
        int g;
        @(negedge clk);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        #2;
        for (int k = 0; k < 2; k++) begin
            g = eg(k, q0, q1);
            cur_g[k] = g;
            chk($sformatf("r0_gnt[%0d]", k), g0[k], g == 0);
            chk($sformatf("r1_gnt[%0d]", k), g1[k], g == 1);
            chk($sformatf("mem_en[%0d]", k), men[k], g >= 0);
            chk($sformatf("mem_we[%0d]", k), mwe[k], (g == 0) ? w0 : ((g == 1) ? w1 : 1'b0));
            chk($sformatf("mem_addr[%0d]", k), maddr[k], (g == 0) ? a0 : ((g == 1) ? a1 : '0));
            chk($sformatf("mem_din[%0d]", k), mdin[k], (g == 0) ? d0 : ((g == 1) ? d1 : '0));
            chk($sformatf("r0_rvalid[%0d]", k), rv0[k], m_pv0[k]);
            chk($sformatf("r1_rvalid[%0d]", k), rv1[k], m_pv1[k]);
            if (m_pv0[k]) chk($sformatf("r0_rdata[%0d]", k), rd0[k], m_pd[k]);
            if (m_pv1[k]) chk($sformatf("r1_rdata[%0d]", k), rd1[k], m_pd[k]);
        end
    endtask

    task automatic commit();
        int g, cap;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            g = cur_g[k];
            cap = (k == 0) ? 16 : 1;
            m_pv0[k] = (g == 0) && !r0_we;
            m_pv1[k] = (g == 1) && !r1_we;
            if (g == 0) begin
                if (r0_we) em[k][r0_addr] = r0_wdata; else m_pd[k] = em[k][r0_addr];
            end else if (g == 1) begin
                if (r1_we) em[k][r1_addr] = r1_wdata; else m_pd[k] = em[k][r1_addr];
            end
            if (g < 0) begin
                m_own[k] = -1; m_run[k] = 0;
            end else begin
                m_run[k]  = (g == m_own[k]) ? ((m_run[k] < cap) ? m_run[k] + 1 : cap) : 1;
                m_own[k]  = g;
                m_last[k] = g;
            end
        end
    endtask

    task automatic step(input bit q0, input bit w0, input logic [ADDR-1:0] a0, input logic [WIDTH-1:0] d0,
                        input bit q1, input bit w1, input logic [ADDR-1:0] a1, input logic [WIDTH-1:0] d1);
        drive_check(q0, w0, a0, d0, q1, w1, a1, d1);
        commit();
    endtask

    // Asserts reset mid-cycle with requests still held; grants must vanish at once.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_gnt0[%0d]", k), g0[k], 1'b0);
            chk($sformatf("rst_gnt1[%0d]", k), g1[k], 1'b0);
            chk($sformatf("rst_en[%0d]", k), men[k], 1'b0);
            chk($sformatf("rst_addr[%0d]", k), maddr[k], '0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bit               q0, q1, w0, w1;
        logic [ADDR-1:0]  a0, a1;
        logic [WIDTH-1:0] d0, d1;
        logic [WIDTH-1:0] zero;
        zero = '0;

        r0_req = 1'b1; r1_req = 1'b1;
        #2 do_reset();

        // Write then read-back of the same address by the other requester.
        step(1, 1, 10'd5, 128'hAA, 0, 0, '0, zero);
        step(0, 0, '0, zero, 1, 0, 10'd5, zero);
        step(0, 0, '0, zero, 0, 0, '0, zero);
        chk("t1_mem_rd", g_inst[0].ram[5], 128'hAA);

        // Continuous contention: 16-grant blocks (cap 16) and alternation (cap 1).
        do_reset();
        for (int i = 0; i < 70; i++)
            step(1, 0, ADDR'($urandom_range(0, 63)), zero, 1, 0, ADDR'($urandom_range(0, 63)), zero);

        // Preload 0..39 by r0, then a lone 40-read stream by r1.
        for (int i = 0; i < 40; i++) step(1, 1, ADDR'(i), rnd_data(), 0, 0, '0, zero);
        for (int i = 0; i < 40; i++) step(0, 0, '0, zero, 1, 0, ADDR'(i), zero);
        step(0, 0, '0, zero, 0, 0, '0, zero);

        // Reset while an r1 read is outstanding drops its rvalid.
        drive_check(0, 0, '0, zero, 1, 0, 10'd3, zero);
        #1 do_reset();
        step(0, 0, '0, zero, 0, 0, '0, zero);
        step(1, 0, 10'd1, zero, 1, 0, 10'd2, zero);

        // An idle gap clears ownership; the next tie goes to ~last.
        step(0, 0, '0, zero, 1, 0, 10'd4, zero);
        step(0, 0, '0, zero, 0, 0, '0, zero);
        step(0, 0, '0, zero, 1, 0, 10'd6, zero);
        step(0, 0, '0, zero, 0, 0, '0, zero);
        step(1, 0, 10'd7, zero, 1, 0, 10'd8, zero);
        chk("t6_tie_r0", g0[0], 1'b1);

        // Random traffic; a stalled requester holds its command.
        q0 = 0; q1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(q0 && cur_g[0] != 0)) begin
                q0 = ($urandom_range(0, 3) != 0); w0 = $urandom_range(0, 1) != 0;
                a0 = ADDR'($urandom_range(0, 15)); d0 = rnd_data();
            end
            if (!(q1 && cur_g[0] != 1)) begin
                q1 = ($urandom_range(0, 3) != 0); w1 = $urandom_range(0, 3) == 0;
                a1 = ADDR'($urandom_range(0, 15)); d1 = rnd_data();
            end
            step(q0, w0, a0, d0, q1, w1, a1, d1);
        end
        step(0, 0, '0, zero, 0, 0, '0, zero);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
